// File: rtl/uart_rx_mem.sv
// Memory-mapped 8N1 UART receiver with a small byte FIFO read over the dmem bus.
// Word 0 pops received bytes, word 1 reports status and clears sticky errors (W1C).
module uart_rx_mem #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [3:0]  writeb,
    input  logic        read,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rx_ready
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // state   | meaning
    // IDLE    | line idle, waiting for a falling edge
    // START   | waiting for start-bit centre to confirm it is not a glitch
    // DATA    | sampling 8 data bits at their centres, LSB first
    // STOP    | sampling stop bit; push on 1, framing error on 0
    // BREAK   | line held low after a bad stop bit, wait for it to go high
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t state, state_d;
    logic sync1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic shift_en, push_req, fe_set;

    logic [7:0] mem [DEPTH];
    logic [FIFO_AW:0] wptr, rptr;
    logic empty, full, pop, push, ovr_set, st_wr;
    logic overrun, frame_err;
    logic unused_bits;

    assign unused_bits = ^{wdata[31:4], wdata[1:0], writeb[3:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        shift_en = 1'b0;
        push_req = 1'b0;
        fe_set   = 1'b0;
        case (state)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (cnt == CNT_HALF) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (cnt == CNT_END) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_END) begin
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            if (state_d != state || state == S_IDLE || state == S_BREAK) cnt <= '0;
            else if (cnt == CNT_END)                                     cnt <= '0;
            else                                                         cnt <= cnt + CW'(1);
            if (state_d != state) bit_idx <= '0;
            else if (shift_en)    bit_idx <= bit_idx + 3'd1;
            if (shift_en) sh <= {rx_s, sh[7:1]};
        end
    end

    // Pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign pop      = read && (addr == 6'd0) && !empty;
    assign push     = push_req && (!full || pop);
    assign ovr_set  = push_req && full && !pop;
    assign st_wr    = writeb[0] && (addr == 6'd1);
    assign rx_ready = !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[FIFO_AW-1:0]] <= sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rdata     <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            overrun   <= ovr_set | (overrun   & ~(st_wr & wdata[2]));
            frame_err <= fe_set  | (frame_err & ~(st_wr & wdata[3]));
            if (read) begin
                case (addr)
                    6'd0:    rdata <= empty ? 32'd0 : {23'd0, 1'b1, mem[rptr[FIFO_AW-1:0]]};
                    6'd1:    rdata <= {28'd0, frame_err, overrun, full, !empty};
                    default: rdata <= 32'd0;
                endcase
            end
        end
    end
endmodule
